dram_user_master: RTL and testbench

Client-side initiator for the BEE3 DDR2 controller's user port (`mem_controller_interface.dram`). Accepts line-granular read/write requests from the CPU/cache side and turns them into the controller's command, write-buffer and read-buffer handshakes.

- Writes: each write's data beats go into the write buffer (WB), then one address-FIFO (AF) entry follows.
- Reads: each read pushes one AF entry. The returned read-buffer (RB) beats are streamed back in order.
- Sits between the cache refill/writeback logic and the controller user port, all in the controller's `clk` domain.

---
 rtl/dram_user_master.sv | 143 ++++++++++++++
 tb/tb_dram_user_master.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/dram_user_master.sv
// Client-side initiator for the DDR2 controller user port: turns line read/write
// requests into write-buffer beats, address-FIFO commands and read-buffer pops.
module dram_user_master #(
  parameter int ADDR_W = 28,
  parameter int DATA_W = 144,
  parameter int BEATS  = 2,
  parameter int MAX_RD = 8
) (
  input  logic                        clk,
  input  logic                        rstn,
  input  logic                        req_valid,
  output logic                        req_ready,
  input  logic                        req_write,
  input  logic [ADDR_W-1:0]           req_addr,
  input  logic                        wd_valid,
  output logic                        wd_ready,
  input  logic [DATA_W-1:0]           wd_data,
  output logic                        wr_done,
  output logic                        rsp_valid,
  input  logic                        rsp_ready,
  output logic [DATA_W-1:0]           rsp_data,
  output logic                        rsp_last,
  output logic [$clog2(MAX_RD+1)-1:0] rd_outstanding,
  output logic [ADDR_W-1:0]           Address,
  output logic                        Read,
  output logic                        WriteAF,
  input  logic                        AFfull,
  output logic [DATA_W-1:0]           WriteData,
  output logic                        WriteWB,
  input  logic                        WBfull,
  input  logic [DATA_W-1:0]           ReadData,
  input  logic                        RBempty,
  output logic                        ReadRB,
  output logic [1:0]                  dbg_state
);

  localparam int BW = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int CW = $clog2(MAX_RD + 1);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_WDATA = 2'd1;
  localparam logic [1:0] S_WCMD  = 2'd2;
  localparam logic [1:0] S_RCMD  = 2'd3;

  logic [1:0]        state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [BW-1:0]     beat_q, beat_d;
  logic [BW-1:0]     rbeat_q, rbeat_d;
  logic [CW-1:0]     rd_cnt_q, rd_cnt_d;
  logic              rd_inc, rd_dec;

  // All handshakes are valid/ready: a transfer happens in a cycle where both are
  // high; the ready side never waits on its own valid, so the paths stay loop-free.
  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    beat_d    = beat_q;
    req_ready = 1'b0;
    wd_ready  = 1'b0;
    WriteWB   = 1'b0;
    WriteAF   = 1'b0;
    Read      = 1'b0;
    wr_done   = 1'b0;
    rd_inc    = 1'b0;
    case (state_q)
      S_IDLE: begin
        req_ready = rstn;
        if (req_valid && rstn) begin
          addr_d  = req_addr;
          beat_d  = '0;
          state_d = req_write ? S_WDATA : S_RCMD;
        end
      end
      S_WDATA: begin
        wd_ready = !WBfull;
        if (wd_valid && !WBfull) begin
          WriteWB = 1'b1;
          if (beat_q == BW'(BEATS - 1)) begin
            beat_d  = '0;
            state_d = S_WCMD;
          end else begin
            beat_d = beat_q + 1'b1;
          end
        end
      end
      S_WCMD: begin
        if (!AFfull) begin
          WriteAF = 1'b1;
          wr_done = 1'b1;
          state_d = S_IDLE;
        end
      end
      default: begin
        if (!AFfull && (rd_cnt_q < CW'(MAX_RD))) begin
          WriteAF = 1'b1;
          Read    = 1'b1;
          rd_inc  = 1'b1;
          state_d = S_IDLE;
        end
      end
    endcase
  end

  // Return path runs independently of the request FSM; gated so nothing pops in reset.
  always_comb begin
    rsp_valid = rstn && !RBempty;
    ReadRB    = rsp_valid && rsp_ready;
    rsp_last  = rsp_valid && (rbeat_q == BW'(BEATS - 1));
    rd_dec    = ReadRB && rsp_last;
    rbeat_d   = rbeat_q;
    if (ReadRB) begin
      rbeat_d = rsp_last ? '0 : rbeat_q + 1'b1;
    end
    rd_cnt_d = rd_cnt_q + CW'(rd_inc) - CW'(rd_dec);
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q  <= S_IDLE;
      addr_q   <= '0;
      beat_q   <= '0;
      rbeat_q  <= '0;
      rd_cnt_q <= '0;
    end else begin
      state_q  <= state_d;
      addr_q   <= addr_d;
      beat_q   <= beat_d;
      rbeat_q  <= rbeat_d;
      rd_cnt_q <= rd_cnt_d;
    end
  end

  assign Address        = addr_q;
  assign WriteData      = wd_data;
  assign rsp_data       = ReadData;
  assign rd_outstanding = rd_cnt_q;
  assign dbg_state      = state_q;

  // Popping read data with nothing in flight means the controller and this block disagree.
  a_no_orphan_pop: assert property (@(posedge clk) disable iff (!rstn)
    !(ReadRB && (rd_cnt_q == '0)));

endmodule

// File: tb/tb_dram_user_master.sv
// Directed bench for dram_user_master: cycle vector table plus reset sequences.
module tb_dram_user_master;

  localparam int ADDR_W = 28;
  localparam int DATA_W = 144;

  localparam logic [8:0] F_RQ   = 9'h100;
  localparam logic [8:0] F_WRDY = 9'h080;
  localparam logic [8:0] F_WB   = 9'h040;
  localparam logic [8:0] F_AF   = 9'h020;
  localparam logic [8:0] F_RD   = 9'h010;
  localparam logic [8:0] F_WD   = 9'h008;
  localparam logic [8:0] F_RV   = 9'h004;
  localparam logic [8:0] F_LAST = 9'h002;
  localparam logic [8:0] F_RRB  = 9'h001;

  logic              clk = 1'b0;
  logic              rstn = 1'b0;
  logic              req_valid = 1'b0, req_ready, req_write = 1'b0;
  logic [ADDR_W-1:0] req_addr = '0;
  logic              wd_valid = 1'b0, wd_ready;
  logic [DATA_W-1:0] wd_data = '0;
  logic              wr_done, rsp_valid, rsp_ready = 1'b0, rsp_last;
  logic [DATA_W-1:0] rsp_data;
  logic [3:0]        rd_outstanding;
  logic [ADDR_W-1:0] Address;
  logic              Read, WriteAF, AFfull = 1'b0;
  logic [DATA_W-1:0] WriteData;
  logic              WriteWB, WBfull = 1'b0;
  logic [DATA_W-1:0] ReadData = '0;
  logic              RBempty = 1'b1, ReadRB;
  logic [1:0]        dbg_state;

  int total = 0;
  int passed = 0;

  always #5 clk = ~clk;

  dram_user_master dut (
    .clk(clk), .rstn(rstn),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write), .req_addr(req_addr),
    .wd_valid(wd_valid), .wd_ready(wd_ready), .wd_data(wd_data), .wr_done(wr_done),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data), .rsp_last(rsp_last),
    .rd_outstanding(rd_outstanding), .Address(Address), .Read(Read), .WriteAF(WriteAF),
    .AFfull(AFfull), .WriteData(WriteData), .WriteWB(WriteWB), .WBfull(WBfull),
    .ReadData(ReadData), .RBempty(RBempty), .ReadRB(ReadRB), .dbg_state(dbg_state)
  );

  typedef struct {
    string             name;
    logic              rv, rw;
    logic [ADDR_W-1:0] addr;
    logic              wv;
    logic [15:0]       wd;
    logic              wbf, aff, rbe, rr;
    logic [15:0]       rd;
    logic [8:0]        ef;
    logic [3:0]        eo;
    logic [ADDR_W-1:0] ea;
  } vec_t;

  vec_t vq[$];

  function automatic vec_t mk(string name, logic rv, logic rw, logic [ADDR_W-1:0] addr,
                              logic wv, logic [15:0] wd, logic wbf, logic aff, logic rbe,
                              logic rr, logic [15:0] rd, logic [8:0] ef, logic [3:0] eo,
                              logic [ADDR_W-1:0] ea);
    vec_t v;
    v.name = name; v.rv = rv; v.rw = rw; v.addr = addr; v.wv = wv; v.wd = wd;
    v.wbf = wbf; v.aff = aff; v.rbe = rbe; v.rr = rr; v.rd = rd;
    v.ef = ef; v.eo = eo; v.ea = ea;
    return v;
  endfunction

  function automatic logic [8:0] flags();
    return {req_ready, wd_ready, WriteWB, WriteAF, Read, wr_done, rsp_valid, rsp_last, ReadRB};
  endfunction

  task automatic chk(string name, logic [DATA_W-1:0] act, logic [DATA_W-1:0] exp);
    total++;
    if (act !== exp) $display("FAIL %s: got %0h expected %0h", name, act, exp);
    else passed++;
  endtask

  task automatic idle_in();
    req_valid = 1'b0; wd_valid = 1'b0; WBfull = 1'b0; AFfull = 1'b0;
    RBempty = 1'b1; rsp_ready = 1'b0;
  endtask

  initial begin
    // Write, no backpressure
    vq.push_back(mk("wr_req",    1, 1, 28'h0000123, 0, 16'h0,    0, 0, 1, 0, 16'h0, F_RQ,        0, 0));
    vq.push_back(mk("wr_beatA",  0, 0, 0,           1, 16'hAAAA, 0, 0, 1, 0, 16'h0, F_WRDY|F_WB, 0, 0));
    vq.push_back(mk("wr_beatB",  0, 0, 0,           1, 16'hBBBB, 0, 0, 1, 0, 16'h0, F_WRDY|F_WB, 0, 0));
    vq.push_back(mk("wr_af",     0, 0, 0,           0, 16'h0,    0, 0, 1, 0, 16'h0, F_AF|F_WD,   0, 28'h0000123));
    vq.push_back(mk("wr_next",   0, 0, 0,           0, 16'h0,    0, 0, 1, 0, 16'h0, F_RQ,        0, 0));
    // Write with WB then AF backpressure
    vq.push_back(mk("bp_req",    1, 1, 28'h0ABCDEF, 0, 16'h0,    0, 0, 1, 0, 16'h0, F_RQ,        0, 0));
    vq.push_back(mk("bp_beatA",  0, 0, 0,           1, 16'hA1A1, 0, 0, 1, 0, 16'h0, F_WRDY|F_WB, 0, 0));
    for (int i = 0; i < 3; i++)
      vq.push_back(mk("bp_wbfull", 0, 0, 0,         1, 16'hB2B2, 1, 0, 1, 0, 16'h0, 9'h000,      0, 0));
    vq.push_back(mk("bp_beatB",  0, 0, 0,           1, 16'hB2B2, 0, 0, 1, 0, 16'h0, F_WRDY|F_WB, 0, 0));
    for (int i = 0; i < 2; i++)
      vq.push_back(mk("bp_affull", 0, 0, 0,         0, 16'h0,    0, 1, 1, 0, 16'h0, 9'h000,      0, 0));
    vq.push_back(mk("bp_af",     0, 0, 0,           0, 16'h0,    0, 0, 1, 0, 16'h0, F_AF|F_WD,   0, 28'h0ABCDEF));
    vq.push_back(mk("bp_next",   0, 0, 0,           0, 16'h0,    0, 0, 1, 0, 16'h0, F_RQ,        0, 0));
    // Eight reads fill the in-flight limit
    for (int i = 0; i < 8; i++) begin
      vq.push_back(mk("rd_req",  1, 0, 28'h100 + i, 0, 16'h0,    0, 0, 1, 0, 16'h0, F_RQ,        4'(i), 0));
      vq.push_back(mk("rd_af",   0, 0, 0,           0, 16'h0,    0, 0, 1, 0, 16'h0, F_AF|F_RD,   4'(i), 28'h100 + i));
    end
    vq.push_back(mk("rd9_req",   1, 0, 28'h108,     0, 16'h0,    0, 0, 1, 0, 16'h0, F_RQ,        8, 0));
    for (int i = 0; i < 2; i++)
      vq.push_back(mk("rd9_held", 0, 0, 0,          0, 16'h0,    0, 0, 1, 0, 16'h0, 9'h000,      8, 0));
    vq.push_back(mk("rb_beat0",  0, 0, 0,           0, 16'h0,    0, 0, 0, 1, 16'h1111, F_RV|F_RRB, 8, 0));
    vq.push_back(mk("rb_beat1",  0, 0, 0,           0, 16'h0,    0, 0, 0, 1, 16'h2222, F_RV|F_LAST|F_RRB, 8, 0));
    vq.push_back(mk("rd9_af",    0, 0, 0,           0, 16'h0,    0, 0, 1, 0, 16'h0, F_AF|F_RD,   7, 28'h108));
    // Response backpressure
    for (int i = 0; i < 4; i++)
      vq.push_back(mk("rsp_stall", 0, 0, 0,         0, 16'h0,    0, 0, 0, 0, 16'h3333, F_RQ|F_RV, 8, 0));
    vq.push_back(mk("rsp_go0",   0, 0, 0,           0, 16'h0,    0, 0, 0, 1, 16'h3333, F_RQ|F_RV|F_RRB, 8, 0));
    vq.push_back(mk("rsp_go1",   0, 0, 0,           0, 16'h0,    0, 0, 0, 1, 16'h4444, F_RQ|F_RV|F_LAST|F_RRB, 8, 0));
    for (int j = 0; j < 4; j++) begin
      vq.push_back(mk("drain0",  0, 0, 0,           0, 16'h0,    0, 0, 0, 1, 16'h5000 + j, F_RQ|F_RV|F_RRB, 4'(7 - j), 0));
      vq.push_back(mk("drain1",  0, 0, 0,           0, 16'h0,    0, 0, 0, 1, 16'h6000 + j, F_RQ|F_RV|F_LAST|F_RRB, 4'(7 - j), 0));
    end
    // Read AF push coincides with a final response pop
    vq.push_back(mk("sim_req",   1, 0, 28'h200,     0, 16'h0,    0, 0, 0, 1, 16'h5555, F_RQ|F_RV|F_RRB, 3, 0));
    vq.push_back(mk("sim_both",  0, 0, 0,           0, 16'h0,    0, 0, 0, 1, 16'h6666, F_AF|F_RD|F_RV|F_LAST|F_RRB, 3, 28'h200));
    vq.push_back(mk("sim_after", 0, 0, 0,           0, 16'h0,    0, 0, 1, 0, 16'h0, F_RQ,        3, 0));

    // Reset state, with RB non-empty to prove the return path is gated
    idle_in();
    RBempty = 1'b0; rsp_ready = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    chk("rst_flags", DATA_W'(flags()), '0);
    chk("rst_addr", DATA_W'(Address), '0);
    chk("rst_outst", DATA_W'(rd_outstanding), '0);
    chk("rst_state", DATA_W'(dbg_state), '0);
    idle_in();
    @(negedge clk);
    rstn = 1'b1;

    foreach (vq[k]) begin
      @(negedge clk);
      req_valid = vq[k].rv; req_write = vq[k].rw; req_addr = vq[k].addr;
      wd_valid = vq[k].wv; wd_data = DATA_W'(vq[k].wd);
      WBfull = vq[k].wbf; AFfull = vq[k].aff; RBempty = vq[k].rbe;
      rsp_ready = vq[k].rr; ReadData = DATA_W'(vq[k].rd);
      #1;
      chk({vq[k].name, "_flags"}, DATA_W'(flags()), DATA_W'(vq[k].ef));
      chk({vq[k].name, "_outst"}, DATA_W'(rd_outstanding), DATA_W'(vq[k].eo));
      if (vq[k].ef[5]) chk({vq[k].name, "_addr"}, DATA_W'(Address), DATA_W'(vq[k].ea));
      if (vq[k].ef[6]) chk({vq[k].name, "_wdata"}, WriteData, DATA_W'(vq[k].wd));
      if (vq[k].ef[2]) chk({vq[k].name, "_rdata"}, rsp_data, DATA_W'(vq[k].rd));
    end

    // Reset asserted in the middle of a write
    @(negedge clk);
    idle_in();
    req_valid = 1'b1; req_write = 1'b1; req_addr = 28'h77;
    @(negedge clk);
    req_valid = 1'b0; wd_valid = 1'b1; wd_data = DATA_W'(16'hAAAA);
    @(negedge clk);
    wd_data = DATA_W'(16'hBBBB);
    #1;
    chk("mid_wdata_state", DATA_W'(dbg_state), DATA_W'(2'd1));
    RBempty = 1'b0;
    rstn = 1'b0;
    #1;
    chk("mid_rst_flags", DATA_W'(flags()), '0);
    chk("mid_rst_addr", DATA_W'(Address), '0);
    chk("mid_rst_outst", DATA_W'(rd_outstanding), '0);
    chk("mid_rst_state", DATA_W'(dbg_state), '0);
    idle_in();
    @(negedge clk);
    rstn = 1'b1;
    #1;
    chk("post_rst_flags", DATA_W'(flags()), DATA_W'(F_RQ));
    chk("post_rst_state", DATA_W'(dbg_state), '0);
    @(negedge clk);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
